// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - execute-issue stage feeding the ALU; optional MULT watchdog via ALU_ISSUE_MULT_WDOG_EN
module alu_issue #(
    parameter int MULT_TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [3:0]  rf_rs_addr,
    output logic [3:0]  rf_rt_addr,
    input  logic [31:0] rf_rs_data,
    input  logic [31:0] rf_rt_data,
    output logic [3:0]  alu_func,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_out,
    input  logic        alu_mult_fin,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err_illegal,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MULT,
        S_WB
    } state_t;

    localparam logic [3:0] FUNC_MULT = 4'd5;

    state_t      state_q, state_d;
    logic        instr_ready_q, instr_ready_d;
    logic [3:0]  alu_func_q, alu_func_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  rd_q, rd_d;
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_timeout_q, err_timeout_d;

    logic [3:0]  dec_opcode;
    logic [3:0]  dec_rd;
    logic [3:0]  dec_func;
    logic [15:0] dec_imm;
    logic        dec_legal;
    logic        dec_sext;
    logic [31:0] dec_b;

`ifdef ALU_ISSUE_MULT_WDOG_EN
    localparam int CNT_W = $clog2(MULT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_TIMEOUT - 1);
    logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
`endif

    assign rf_rs_addr = instr[23:20];
    assign rf_rt_addr = instr[3:0];

    assign dec_opcode = instr[31:28];
    assign dec_rd     = instr[27:24];
    assign dec_func   = instr[19:16];
    assign dec_imm    = instr[15:0];

    // Decode legality and the b operand (register, sign- or zero-extended immediate)
    always_comb begin
        dec_legal = 1'b0;
        dec_sext  = 1'b0;
        dec_b     = rf_rt_data;
        case (dec_func)
            4'd0, 4'd2, 4'd5:     begin dec_legal = 1'b1; dec_sext = 1'b1; end
            4'd11, 4'd13, 4'd14,
            4'd15:                begin dec_legal = 1'b1; dec_sext = 1'b0; end
            default:              begin dec_legal = 1'b0; dec_sext = 1'b0; end
        endcase
        if (dec_opcode > 4'h1) begin
            dec_legal = 1'b0;
        end
        if (dec_opcode == 4'h1) begin
            dec_b = dec_sext ? {{16{dec_imm[15]}}, dec_imm} : {16'd0, dec_imm};
        end
    end

    // Next-state and next-output computation; ALU operand registers double as the latched operands
    always_comb begin
        state_d       = state_q;
        instr_ready_d = instr_ready_q;
        alu_func_d    = alu_func_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        rd_d          = rd_q;
        wb_valid_d    = wb_valid_q;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;
`ifdef ALU_ISSUE_MULT_WDOG_EN
        wdog_cnt_d    = wdog_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    if (dec_legal) begin
                        alu_func_d    = dec_func;
                        alu_a_d       = rf_rs_data;
                        alu_b_d       = dec_b;
                        rd_d          = dec_rd;
                        instr_ready_d = 1'b0;
                        state_d       = (dec_func == FUNC_MULT) ? S_MULT : S_EXEC;
`ifdef ALU_ISSUE_MULT_WDOG_EN
                        wdog_cnt_d    = '0;
`endif
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            S_EXEC, S_MULT: begin
                if (state_q == S_EXEC || alu_mult_fin) begin
                    alu_func_d = 4'd0;
                    alu_a_d    = 32'd0;
                    alu_b_d    = 32'd0;
                    if (rd_q != 4'd0) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = alu_out;
                        state_d    = S_WB;
                    end else begin
                        instr_ready_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
`ifdef ALU_ISSUE_MULT_WDOG_EN
                else if (wdog_cnt_q == CNT_LAST) begin
                    err_timeout_d = 1'b1;
                    alu_func_d    = 4'd0;
                    alu_a_d       = 32'd0;
                    alu_b_d       = 32'd0;
                    instr_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end
            S_WB: begin
                if (wb_ready) begin
                    wb_valid_d    = 1'b0;
                    instr_ready_d = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            instr_ready_q <= 1'b1;
            alu_func_q    <= 4'd0;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            rd_q          <= 4'd0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= 4'd0;
            wb_data_q     <= 32'd0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_ready_q <= instr_ready_d;
            alu_func_q    <= alu_func_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            rd_q          <= rd_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

`ifdef ALU_ISSUE_MULT_WDOG_EN
    // Watchdog cycle counter for time spent in MULT
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`endif

    assign instr_ready = instr_ready_q;
    assign alu_func    = alu_func_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;

endmodule
